// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order word requests to
// instruction memory and buffers returned words in a prefetch FIFO for decode.
module fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 2,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        is_branch_taken,
    input  logic [15:0] branch_target,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    output logic [15:0] instr,
    output logic        instr_valid,
    output logic [15:0] instr_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0]   DEPTH_W = DEPTH[CW:0];
    localparam logic [CW-1:0] MAX_W   = MAX_OUT[CW-1:0];

    logic [15:0]   pc;
    logic [15:0]   rsp_pc;
    logic [15:0]   fifo_data [DEPTH];
    logic [15:0]   fifo_pc   [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;

    logic [CW:0] credits_used;
    logic        grant;
    logic        rsp;
    logic        dropping;
    logic        push;
    logic        pop;

    // A request is only issued when its response is guaranteed a FIFO slot,
    // so the FIFO can never overflow.
    always_comb begin
        credits_used = {1'b0, count} + {1'b0, outstanding};
        imem_req     = !reset && !is_branch_taken
                       && (outstanding < MAX_W) && (credits_used < DEPTH_W);
        imem_addr    = pc;
        instr_valid  = (count != '0) && !is_branch_taken;
        instr        = instr_valid ? fifo_data[rd_ptr] : 16'h0000;
        instr_pc     = instr_valid ? fifo_pc[rd_ptr]   : 16'h0000;
        grant        = imem_req && imem_gnt;
        rsp          = imem_rvalid && (outstanding != '0);
        dropping     = drop_cnt != '0;
        push         = rsp && !dropping && !is_branch_taken;
        pop          = instr_valid && !stall;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CW'(grant) - CW'(rsp);
            if (is_branch_taken) begin
                // Everything still in flight belongs to the old path, including
                // a response arriving in this very cycle.
                pc       <= branch_target;
                rsp_pc   <= branch_target;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                drop_cnt <= outstanding - CW'(rsp);
            end else begin
                if (grant) pc <= pc + 16'd1;
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    rsp_pc <= rsp_pc + 16'd1;
                end
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(push) - CW'(pop);
                if (rsp && dropping) drop_cnt <= drop_cnt - 1'b1;
            end
        end
    end

    // NOTE: FIFO storage has no reset; the count qualifies every read, so
    // clearing the array would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]   <= rsp_pc;
        end
    end

endmodule
